// File: rtl/disp_scan_pkg.sv
// disp_scan shared definitions: segment code table, blanking constants
// and the leading-zero mask helper used when DISP_SCAN_LZB_EN is defined.
package disp_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low g..a patterns, entry n is hex digit n.
    localparam logic [15:0][6:0] SEG_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    // Bit k set when nibbles k..7 of the word are all zero; digit 0 never set.
    function automatic logic [7:0] lz_mask(input logic [31:0] w);
        logic [7:0] m;
        m = '0;
        for (int k = 1; k < 8; k++) begin
            m[k] = (w >> (4 * k)) == 32'd0;
        end
        return m;
    endfunction

endpackage

// File: rtl/disp_scan_if.sv
// disp_scan bus: snapshot inputs from the test logic and the
// multiplexed display drive outputs.
interface disp_scan_if;

    logic [31:0] DATA;
    logic [7:0]  DP;
    logic        FREEZE;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DPO;
    logic        FRAME;

    modport master (
        output DATA, DP, FREEZE,
        input  AN, SEG, DPO, FRAME
    );

    modport slave (
        input  DATA, DP, FREEZE,
        output AN, SEG, DPO, FRAME
    );

endinterface

// File: rtl/disp_scan_hex2seg.sv
// hex2seg: combinational 4-bit hex digit to active-low
// seven-segment pattern (g..a).
module hex2seg
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TBL[nib];

endmodule

// File: rtl/disp_scan.sv
// disp_scan: 8-digit multiplexed seven-segment scanner with frame snapshot.
// Define DISP_SCAN_LZB_EN to enable leading-zero blanking.
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned DIV = 1000,
    parameter int unsigned GAP = 2
) (
    input logic        CLK,
    input logic        RESET,
    disp_scan_if.slave bus
);

    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
    localparam logic [15:0] CNT_GAP  = 16'(GAP);

    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [31:0] snap;
    logic [7:0]  dp_snap;
    logic        slot_end;
    logic        load;
    logic        lit;
    logic [3:0]  nib;
    logic [6:0]  seg_code;
    logic [6:0]  seg_next;

    assign slot_end = cnt == CNT_LAST;
    assign load     = slot_end && (idx == 3'd7) && !bus.FREEZE;
    assign lit      = cnt >= CNT_GAP;
    assign nib      = snap[{idx, 2'b00} +: 4];

    hex2seg u_hex2seg (
        .nib (nib),
        .seg (seg_code)
    );

`ifdef DISP_SCAN_LZB_EN
    logic [7:0] blank;

    // Blanking mask travels with the snapshot so it always matches snap.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            blank <= 8'hFE;
        end else if (load) begin
            blank <= lz_mask(bus.DATA);
        end
    end

    assign seg_next = blank[idx] ? SEG_OFF : seg_code;
`else
    assign seg_next = seg_code;
`endif

    // Slot counter and digit index advance.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Frame snapshot, taken at the last cycle of digit 7 only.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            snap    <= '0;
            dp_snap <= '0;
        end else if (load) begin
            snap    <= bus.DATA;
            dp_snap <= bus.DP;
        end
    end

    // Registered display drive; anodes dark during the slot's gap.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bus.AN    <= AN_OFF;
            bus.SEG   <= SEG_OFF;
            bus.DPO   <= 1'b1;
            bus.FRAME <= 1'b0;
        end else begin
            bus.FRAME <= load;
            if (lit) begin
                bus.AN  <= ~(8'b1 << idx);
                bus.SEG <= seg_next;
                bus.DPO <= ~dp_snap[idx];
            end else begin
                bus.AN  <= AN_OFF;
                bus.SEG <= SEG_OFF;
                bus.DPO <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: scoreboard bench for disp_scan (DIV=8, GAP=2).
// Build with DISP_SCAN_LZB_EN defined to exercise leading-zero blanking.
`timescale 1ns/1ps
module tb_disp_scan;

    localparam int DIV = 8;
    localparam int GAP = 2;
    localparam int FR  = 8 * DIV;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    disp_scan_if bus ();

    disp_scan #(.DIV(DIV), .GAP(GAP)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dpo;
        logic       frame;
    } exp_t;

    exp_t        q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          mon_en      = 1'b0;
    int          t           = 0;
    logic [31:0] m_snap      = '0;
    logic [7:0]  m_dp        = '0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the registered outputs it produces.
    task automatic step(input logic [31:0] d, input logic [7:0] p,
                        input logic f);
        exp_t       e;
        int         c;
        int         k;
        logic       ld;
        logic [3:0] n;
        bus.DATA   = d;
        bus.DP     = p;
        bus.FREEZE = f;
        c  = t % DIV;
        k  = (t / DIV) % 8;
        ld = ((t % FR) == FR - 1) && !f;
        e.frame = ld;
        if (c < GAP) begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dpo = 1'b1;
        end else begin
            e.an    = 8'hFF;
            e.an[k] = 1'b0;
            n       = m_snap[4*k +: 4];
            e.seg   = seg_of(n);
`ifdef DISP_SCAN_LZB_EN
            if (k > 0 && (m_snap >> (4 * k)) == 32'd0) e.seg = 7'h7F;
`endif
            e.dpo = ~m_dp[k];
        end
        q.push_back(e);
        if (ld) begin
            m_snap = d;
            m_dp   = p;
        end
        t++;
        @(negedge CLK);
    endtask

    // Monitor: one-hot anode check every cycle, scoreboard pop when armed.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            check("an_onehot", 32'($countones(~bus.AN) <= 1), 32'd1);
            if (mon_en && q.size() > 0) begin
                e = q.pop_front();
                check("an", 32'(bus.AN), 32'(e.an));
                check("seg", 32'(bus.SEG), 32'(e.seg));
                check("dpo", 32'(bus.DPO), 32'(e.dpo));
                check("frame", 32'(bus.FRAME), 32'(e.frame));
            end
        end
    end

    initial begin
        logic [31:0] rd;
        bus.DATA   = '0;
        bus.DP     = '0;
        bus.FREEZE = 1'b0;
        #1 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_an", 32'(bus.AN), 32'hFF);
        check("rst_seg", 32'(bus.SEG), 32'h7F);
        check("rst_dpo", 32'(bus.DPO), 32'd1);
        check("rst_frame", 32'(bus.FRAME), 32'd0);

        RESET  = 1'b1;
        mon_en = 1'b1;
        repeat (2 * FR) step(32'h1234ABCD, 8'h00, 1'b0);

        for (int i = 0; i < FR; i++)
            step((i < 3 * DIV) ? 32'h1234ABCD : 32'h0, 8'h00, 1'b0);
        repeat (FR) step(32'h0, 8'h00, 1'b0);

        for (int i = 0; i < FR; i++)
            step($urandom, 8'h0F, (i >= FR / 2) ? 1'b1 : 1'b0);
        for (int i = 0; i < FR; i++)
            step($urandom, 8'hF0, (i < FR / 2) ? 1'b1 : 1'b0);
        repeat (FR) step(32'hFEDC5678, 8'h81, 1'b0);
        repeat (FR) step(32'hFEDC5678, 8'h81, 1'b0);

`ifdef DISP_SCAN_LZB_EN
        repeat (2 * FR) step(32'h000000A0, 8'h04, 1'b0);
`endif

        for (int i = 0; i < 10 * FR; i++) begin
            rd = 32'($urandom) >> (4 * $urandom_range(0, 7));
            step(rd, 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        while (!((t % DIV) == 5 && ((t / DIV) % 8) == 6))
            step($urandom, 8'($urandom), 1'b0);
        RESET  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("async_an", 32'(bus.AN), 32'hFF);
        check("async_seg", 32'(bus.SEG), 32'h7F);
        check("async_dpo", 32'(bus.DPO), 32'd1);
        check("async_frame", 32'(bus.FRAME), 32'd0);
        q.delete();
        repeat (2) @(negedge CLK);
        m_snap = '0;
        m_dp   = '0;
        t      = 0;
        RESET  = 1'b1;
        mon_en = 1'b1;
        repeat (3 * FR) step($urandom, 8'($urandom), 1'b0);

        @(posedge CLK);
        #2;
        check("drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter DIV, default 1000: CLK cycles per digit slot; legal range 4..65535.
REQ-002 Parameter GAP, default 2: all-anodes-off cycles at the start of each slot; legal range 1..DIV-2.
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 DATA  input  32  test word from comp TR; nibble k is shown on digit k.
REQ-006 DP  input  8  decimal-point request; bit k drives digit k.
REQ-007 FREEZE  input  1  when 1, suppresses the snapshot update.
REQ-008 AN  output  8  digit enables, active-low; bit k selects digit k.
REQ-009 SEG  output  7  segments g..a, active-low.
REQ-010 DPO  output  1  decimal point, active-low.
REQ-011 FRAME  output  1  one-cycle pulse on each snapshot load.

Function
REQ-012 Slot counter cnt runs 0..DIV-1 and wraps to 0; digit index idx is 3 bits and increments when cnt wraps; idx 7->0 wraps.
REQ-013 Snapshot register snap[31:0] and dp_snap[7:0] load DATA and DP on the cycle where cnt=DIV-1 and idx=7, unless FREEZE=1.
REQ-014 FRAME=1 exactly on the cycle after a snapshot load; otherwise 0.
REQ-015 While cnt<GAP: AN=8'hFF, SEG=7'h7F, DPO=1 (ghost suppression).
REQ-016 While cnt>=GAP: AN = ~(1<<idx); SEG = hex code of snap[4*idx+3:4*idx]; DPO = ~dp_snap[idx].
REQ-017 Hex codes are the standard 0-F patterns, active-low (0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E).
REQ-018 All outputs are registered; the first lit cycle of a slot is cnt=GAP, observed on the following edge.
REQ-019 DATA changes mid-frame do not affect displayed digits until the next snapshot (no tearing).
REQ-020 Exactly one AN bit is ever low; AN is never low while SEG is transitioning between digits.

Reset
REQ-021 RESET low asynchronously forces cnt=0, idx=0, snap=0, dp_snap=0, AN=8'hFF, SEG=7'h7F, DPO=1, FRAME=0.
REQ-022 After RESET is released, the first snapshot occurs after 8*DIV cycles; until then digits show "0".
REQ-023 RESET asserted mid-slot or mid-frame aborts the scan immediately, with no partial snapshot.

Configuration
REQ-024 Macro DISP_SCAN_LZB_EN, when defined, enables leading-zero blanking: digit k>0 is blanked (SEG=7'h7F, AN still driven) if snap nibbles k..7 are all zero; digit 0 is never blanked; DP, when requested, is still shown on a blanked digit.
REQ-025 When DISP_SCAN_LZB_EN is undefined, all eight digits always show their nibble.

Structure
REQ-026 Shared package disp_pkg holds the 16-entry segment code table, the SEG_OFF constant 7'h7F and the AN_OFF constant 8'hFF.
REQ-027 Sub-module hex2seg (4-bit in, 7-bit active-low out, combinational) performs the decode; disp_scan instantiates it once.
REQ-028 The leading-zero mask is computed combinationally from snap and registered with the snapshot.

Verification
REQ-029 DIV=8, GAP=2, DATA=32'h1234ABCD, DP=0; run 2 frames -> second frame shows AN=8'hFE with SEG=7'h21 (D), through AN=8'h7F with SEG=7'h79 (1); first 2 cycles of every slot have AN=8'hFF.
REQ-030 Change DATA to 32'h0 at idx=3 of frame 2 -> remaining digits of frame 2 are unchanged; frame 3 shows all 7'h40; FRAME pulses once per 64 cycles.
REQ-031 FREEZE=1 across a frame boundary with DATA changing -> no FRAME pulse; old digits persist.
REQ-032 With DISP_SCAN_LZB_EN, DATA=32'h0000_00A0, DP=8'h04 -> digits 3..7 blank; digit 2 blank with DPO=0; digits 1,0 show A,0.
REQ-033 Assert RESET at cnt=5, idx=6 -> AN=8'hFF and SEG=7'h7F within the same cycle, without waiting for CLK; after release, idx restarts at 0 and digits show 0 until the first FRAME pulse.
REQ-034 Assertion on all runs: popcount(~AN)<=1 every cycle.
